// File: rtl/mas8_pkg.sv
// mas8_pkg: shared constants and types for the mem_arbiter slice.
//   MEM_AW / MEM_DW : geometry of the mem_256x16 data memory
//   state_t         : arbiter FSM encoding (IDLE -> ACCESS -> RESP)
//   RW_READ/RW_WRITE: memory rw pin encoding (1 = read, 0 = write)
//   ptr_w()         : pointer/index width for a given requester count
package mas8_pkg;
  localparam int MEM_AW = 8;
  localparam int MEM_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  function automatic int ptr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side handshake bus plus memory pins of the arbiter.
//   req/we/addr/wdata[/lock] : requester commands, packed per requester
//   ack/rdata/busy           : completion side back to the requesters
//   mem_en/rw/addr/din/dout  : pins of the shared mem_256x16
// Modports: slave = arbiter view, master = requesters + memory view.
// Optional: MEM_ARB_LOCK_EN adds the per-requester lock signal.
interface mem_arbiter_if import mas8_pkg::*; #(
  parameter int N_REQ = 2,
  parameter int AW    = MEM_AW,
  parameter int DW    = MEM_DW
) ();
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    we;
  logic [N_REQ*AW-1:0] addr;
  logic [N_REQ*DW-1:0] wdata;
`ifdef MEM_ARB_LOCK_EN
  logic [N_REQ-1:0]    lock;
`endif
  logic [N_REQ-1:0]    ack;
  logic [DW-1:0]       rdata;
  logic                busy;
  logic                mem_en;
  logic                mem_rw;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_din;
  logic [DW-1:0]       mem_dout;

`ifdef MEM_ARB_LOCK_EN
  modport slave  (input  req, we, addr, wdata, lock, mem_dout,
                  output ack, rdata, busy, mem_en, mem_rw, mem_addr, mem_din);
  modport master (output req, we, addr, wdata, lock, mem_dout,
                  input  ack, rdata, busy, mem_en, mem_rw, mem_addr, mem_din);
`else
  modport slave  (input  req, we, addr, wdata, mem_dout,
                  output ack, rdata, busy, mem_en, mem_rw, mem_addr, mem_din);
  modport master (output req, we, addr, wdata, mem_dout,
                  input  ack, rdata, busy, mem_en, mem_rw, mem_addr, mem_din);
`endif
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   i_req : request vector
//   i_ptr : index with highest priority this round
//   o_gnt : one-hot winner, o_idx : winner index, o_any : some request present
// The winner is the first set request found scanning upward from i_ptr, wrapping.
module rr_pick import mas8_pkg::*; #(
  parameter int N_REQ = 2,
  parameter int PW    = ptr_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [PW-1:0]    o_idx,
  output logic             o_any
);
  always_comb begin
    int k;
    k     = 0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    // Scan farthest offset first so the nearest request to the pointer overwrites.
    for (int off = N_REQ - 1; off >= 0; off--) begin
      k = (int'(i_ptr) + off) % N_REQ;
      if (i_req[k]) begin
        o_gnt    = '0;
        o_gnt[k] = 1'b1;
        o_idx    = PW'(k);
        o_any    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin access controller in front of one mem_256x16.
//   clk        : system clock, rising edge
//   rstz       : asynchronous active-low reset
//   dvdd/dgnd  : supply pins, no logic function
//   bus        : mem_arbiter_if.slave (requester handshake + memory pins)
// One access takes three cycles: IDLE (pick, load memory command registers),
// ACCESS (memory executes; read data captured at the closing edge), RESP (ack).
// All outputs come straight from registers.
// Optional: MEM_ARB_LOCK_EN lets the current winner keep top priority when
// its lock bit is high in RESP (atomic read-modify-write sequences).
module mem_arbiter import mas8_pkg::*; #(
  parameter int N_REQ = 2,       // legal 2..4
  parameter int AW    = MEM_AW,  // must cover the 256-word memory
  parameter int DW    = MEM_DW
) (
  input  logic         clk,
  input  logic         rstz,
  inout  wire          dvdd,
  inout  wire          dgnd,
  mem_arbiter_if.slave bus
);
  localparam int PW = ptr_w(N_REQ);

  state_t           r_state;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_gidx;
  logic             r_mem_en;
  logic             r_mem_rw;
  logic [AW-1:0]    r_mem_addr;
  logic [DW-1:0]    r_mem_din;
  logic [N_REQ-1:0] r_ack;
  logic [DW-1:0]    r_rdata;
  logic             r_busy;

  logic [N_REQ-1:0] w_gnt;
  logic [PW-1:0]    w_idx;
  logic             w_any;
  logic [PW-1:0]    w_ptr_adv;
  logic [PW-1:0]    w_ptr_nxt;
  logic             w_unused_pwr;

  assign w_unused_pwr = dvdd ^ dgnd ^ (|w_gnt);

  rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  always_comb begin
    w_ptr_adv = (r_gidx == PW'(N_REQ - 1)) ? '0 : r_gidx + PW'(1);
`ifdef MEM_ARB_LOCK_EN
    w_ptr_nxt = bus.lock[r_gidx] ? r_gidx : w_ptr_adv;
`else
    w_ptr_nxt = w_ptr_adv;
`endif
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_gidx     <= '0;
      r_mem_en   <= 1'b0;
      r_mem_rw   <= RW_READ;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_ack      <= '0;
      r_rdata    <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // req is only looked at here; changes during ACCESS/RESP are ignored.
          if (w_any) begin
            r_mem_en   <= 1'b1;
            r_mem_rw   <= ~bus.we[w_idx];
            r_mem_addr <= bus.addr[int'(w_idx)*AW +: AW];
            r_mem_din  <= bus.wdata[int'(w_idx)*DW +: DW];
            r_gidx     <= w_idx;
            r_busy     <= 1'b1;
            r_state    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Memory read is combinational: dout is valid by the end of this cycle.
          if (r_mem_rw == RW_READ) r_rdata <= bus.mem_dout;
          r_mem_en <= 1'b0;
          r_ack    <= N_REQ'(1) << r_gidx;
          r_state  <= ST_RESP;
        end
        ST_RESP: begin
          r_ack   <= '0;
          r_busy  <= 1'b0;
          r_ptr   <= w_ptr_nxt;
          r_state <= ST_IDLE;
        end
        default: begin
          r_mem_en <= 1'b0;
          r_ack    <= '0;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ack      = r_ack;
  assign bus.rdata    = r_rdata;
  assign bus.busy     = r_busy;
  assign bus.mem_en   = r_mem_en;
  assign bus.mem_rw   = r_mem_rw;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_din  = r_mem_din;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin access controller sharing one mem_256x16 data memory between N_REQ requesters (fetch, load/store, debug). Each requester presents a read or write command with a req/ack handshake. The arbiter selects one, drives the memory's en/rw/addr/din from registers, captures read data, and returns a single-cycle ack. It sits between the core-side masters and the memory instance, and it is the only driver of the memory's control pins.

## Interface
- N_REQ, 2: number of requesters, legal 2..4
- AW, 8: address width; must match the memory depth of 256
- DW, 16: data width
- clk  input  1  system clock, rising edge
- rstz  input  1  asynchronous active-low reset
- dvdd  inout  1  digital supply, no logic function
- dgnd  inout  1  digital ground, no logic function
- req  input  N_REQ  request per requester; held until its ack
- we  input  N_REQ  1 = write, 0 = read; held with req
- addr  input  N_REQ*AW  packed addresses; requester i uses slice [i*AW +: AW]
- wdata  input  N_REQ*DW  packed write data
- lock  input  N_REQ  keep the grant for the next access; present only with MEM_ARB_LOCK_EN
- ack  output  N_REQ  one-cycle completion pulse, at most one bit set
- rdata  output  DW  read data; valid in the ack cycle of a read
- busy  output  1  high whenever state is not IDLE
- mem_en, mem_rw  output  1 each  to memory en and rw (rw: 1 = read, 0 = write)
- mem_addr  output  AW  to memory addr
- mem_din  output  DW  to memory din
- mem_dout  input  DW  from memory dout

## Operation
- State machine IDLE -> ACCESS -> RESP -> IDLE.
- IDLE
  - If any req is high, the picker selects a winner.
  - Registers load: mem_en=1, mem_rw=~we[w], mem_addr=addr[w], mem_din=wdata[w], grant index=w.
  - Go to ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS
  - Memory executes the command.
  - A write commits at the closing edge.
  - A read is combinational, so rdata <= mem_dout at the closing edge.
  - mem_en <= 0. Go to RESP.
- RESP
  - ack[w]=1, busy=1.
  - Round-robin pointer <= w+1 mod N_REQ.
  - Go to IDLE.
- Round-robin priority: the search starts at the pointer, wraps, and the lowest index at or after the pointer wins. Pointer resets to 0.
- Handshake rules:
  - A requester keeps req, we, addr and wdata stable until it samples ack.
  - In the cycle after ack it either drops req or presents a new command.
  - The arbiter ignores req changes outside IDLE.
- rdata holds its last read value across writes and idle cycles. It changes only at the end of ACCESS for a read.
- Write/read to the same address back-to-back by different requesters: ordered by grant, so the read returns the new data.
- Reset values: state IDLE, mem_en=0, mem_rw=1, mem_addr=0, mem_din=0, ack=0, rdata=0, busy=0, pointer=0.
- Reset mid-operation: all registers clear asynchronously. mem_en drops before the next edge, so an in-flight write is not committed and no ack is issued.
  - The memory contents are also cleared by its own synchronous reset on the same rstz.

## Timing
- Latency: req sampled at edge k, memory command active in cycle k+1, ack and rdata valid in cycle k+2.
- Throughput: one access per 3 cycles under continuous requests.
- All outputs are registered. No combinational path from req to mem_* or ack.
- mem_dout is sampled only at the end of ACCESS. The combinational memory read path is then one cycle, clk to clk.

## Configuration
- MEM_ARB_LOCK_EN defined:
  - lock port exists.
  - If lock[w] is high in RESP, the pointer stays at w instead of advancing. The next IDLE grants w first if req[w] is high; otherwise normal round-robin applies from w.
  - Used for atomic read-modify-write sequences.
- MEM_ARB_LOCK_EN undefined:
  - No lock port.
  - The pointer always advances. Pure round-robin.

## Structure
- Shared package mas8_pkg holds:
  - MEM_AW=8, MEM_DW=16
  - state encoding ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2
  - rw encoding RW_READ=1, RW_WRITE=0
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, grant index, any.
  - Parameterised by N_REQ.

## Test plan
- Single read: preload mem[0x10]=0xBEEF. Req0 read 0x10 at edge 0 -> mem_en=1, mem_rw=1 in cycle 1; ack[0] and rdata=0xBEEF in cycle 2.
- Write then read: req1 write 0x20=0x1234, then req0 read 0x20 -> ack[1] in cycle 2, ack[0] in cycle 5 with rdata=0x1234.
- Fairness: req0 and req1 held high for 12 cycles with pointer=0 -> acks alternate 0,1,0,1 at cycles 2,5,8,11.
- Reset during ACCESS of a write to 0x30=0xAAAA: rstz low mid-cycle -> mem_en=0 immediately, no ack; after release, a read of 0x30 returns 0x0000.
- Lock (MEM_ARB_LOCK_EN): req0 with lock=1 and req1 both high -> req0 granted twice consecutively, then req1. Without the macro, grants alternate.
- Idle hold: no req for 10 cycles after a read of 0xBEEF -> busy=0, mem_en=0, rdata stays 0xBEEF.
